aes_key_sched_iter: RTL and testbench
=====================================

# aes_key_sched_iter

Iterative, multi-mode AES key scheduler for the encryption datapath. It accepts a 128/192/256-bit cipher key and generates one expanded word per cycle from a sliding window of the last Nk words. Words are packed into 128-bit round keys and streamed out over a valid/ready handshake. It sits between key load and the round pipeline, and replaces a flat fully-combinational 1408-bit expansion with a small sequential engine that supports all three key sizes.

## Interface
- MAX_NK, default 8: largest key size supported, in words (4, 6 or 8). Modes above this are rejected.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_vld  in  1  start request; sampled with i_mode/i_key.
- i_mode  in  2  0 = AES-128 (Nk4/Nr10), 1 = AES-192 (Nk6/Nr12), 2 = AES-256 (Nk8/Nr14), 3 = illegal.
- i_key  in  [0:255]  key, left-aligned (word 0 = bits 0..31); unused tail ignored.
- i_rdy  in  1  downstream accepts o_rk this cycle.
- o_rk  out  [0:127]  round key, words w[4r..4r+3], big-endian.
- o_rk_idx  out  4  round index r of o_rk.
- o_vld  out  1  o_rk/o_rk_idx valid.
- o_busy  out  1  expansion in progress.
- o_done  out  1  one-cycle pulse after the final round key is accepted.
- o_err  out  1  one-cycle pulse on a rejected start.

## Operation
- States: IDLE, GEN, DRAIN.
- IDLE, i_vld=1, legal mode (Nk ≤ MAX_NK): latch Nk/Nr, set word counter i=0, rcon=8'h01, go to GEN, o_busy=1.
- IDLE, illegal mode: o_err pulses, stay in IDLE.
- i_vld while o_busy is ignored.
- GEN: one word per productive cycle. For i<Nk, the word is key word i. Otherwise temp=w[i-1]:
  - when i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon) (0x80 → 0x1b).
  - when Nk=8 and i mod Nk = 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
- i mod Nk is tracked with a wrapping counter, with no divider. The window is an 8-word shift register, and w[i-Nk] is selected by mode.
- Each word is appended to a 4-word assembly buffer. When the buffer holds 4 words it transfers to o_rk, which sets o_vld and o_rk_idx=i/4. The transfer happens only if o_vld=0 or i_rdy=1 in that cycle. Otherwise the 4th word is held and generation stalls: i, the window and rcon are all frozen.
- After word 4(Nr+1)-1 is written to the buffer, go to DRAIN. When the final round key handshake completes, o_done pulses, o_busy drops and the state returns to IDLE.
- o_rk and o_rk_idx stay stable while o_vld=1 and i_rdy=0.

## Timing
- Reset values: o_rk=0, o_rk_idx=0, o_vld=0, o_busy=0, o_done=0, o_err=0, state IDLE, rcon=8'h01. Reset mid-expansion aborts immediately and no o_done is produced.
- Start accepted at edge T0: o_busy=1 after T0. Word k is written at edge T0+1+k when there is no stall.
- With i_rdy held high:
  - RK r is valid after edge T0+4+4r.
  - The last RK (r=Nr) is valid after edge T0+4(Nr+1), i.e. T0+44, T0+52 and T0+60 for the three modes.
  - o_done is high in the cycle after the final handshake edge.
- Throughput is one round key per 4 cycles. Backpressure never drops or duplicates a round key.
- o_err is high for exactly the cycle after the rejected-start edge.
- A new start is accepted in the cycle where o_done is high (o_busy=0).

## Structure
- Shared package aes_pkg: mode encoding, the NK_OF/NR_OF constant functions, the xtime function, and RK_W=128.
- One sub-module, aes_sbox: an 8-bit combinational S-box. It is instantiated 4× for SubWord, and the same instance is reused for the Nk=8 i mod 8 = 4 case.
- rcon is a register, not a table.

## Test plan
- AES-128, FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, i_rdy=1 -> RK0 = key; RK10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at o_rk_idx=10, valid after T0+44; o_done follows.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> RK12 = e98ba06f448c773c8ecc720401002202 valid after T0+52.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> RK14 = fe4890d1e6188d0b046df344706c631e valid after T0+60.
- AES-128 with i_rdy random 30% high -> the same 11 round keys, in order, each once; o_rk is stable while stalled.
- i_mode=3 -> o_err pulses for 1 cycle, o_busy stays 0. With MAX_NK=4 and i_mode=2 -> the same response. A second i_vld during GEN -> ignored, and the output sequence is unchanged.
- i_rst asserted mid-expansion after RK3 -> all outputs are 0 immediately. A following AES-128 start -> the full correct sequence.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: mode encoding, per-mode key/round
// counts and GF(2^8) doubling.
package aes_pkg;

  localparam int unsigned RK_W = 128;

  typedef enum logic [1:0] {
    MODE_128 = 2'd0,
    MODE_192 = 2'd1,
    MODE_256 = 2'd2,
    MODE_ILL = 2'd3
  } aes_mode_e;

  function automatic logic [3:0] NK_OF(input logic [1:0] mode);
    case (mode)
      2'd0:    return 4'd4;
      2'd1:    return 4'd6;
      2'd2:    return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] NR_OF(input logic [1:0] mode);
    case (mode)
      2'd0:    return 4'd10;
      2'd1:    return 4'd12;
      2'd2:    return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  logic [7:0] w_sq;
  logic [7:0] w_inv;

  // Inverse as a^254 = product of a^(2^k) for k=1..7; maps 0 to 0.
  always_comb begin
    w_sq  = i_a;
    w_inv = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      w_sq  = gf_mul(w_sq, w_sq);
      w_inv = gf_mul(w_inv, w_sq);
    end
    o_s = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
        ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_sched_iter.sv
// Iterative AES-128/192/256 key expansion: one word per cycle from an
// 8-word sliding window, packed into 128-bit round keys on a valid/ready port.
module aes_key_sched_iter
  import aes_pkg::*;
#(
  parameter int unsigned MAX_NK = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_vld,
  input  logic [1:0]      i_mode,
  input  logic [0:255]    i_key,
  input  logic            i_rdy,
  output logic [0:RK_W-1] o_rk,
  output logic [3:0]      o_rk_idx,
  output logic            o_vld,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DRAIN} state_e;

  state_e      r_state;
  logic [3:0]  r_nk;
  logic [3:0]  r_nr;
  logic [5:0]  r_i;
  logic [2:0]  r_imod;
  logic [7:0]  r_rcon;
  logic [31:0] r_win [8];
  logic [31:0] r_buf [3];

  logic [3:0]  w_nk;
  logic        w_legal;
  logic [31:0] w_key_win [8];
  logic [31:0] w_old;
  logic        w_key_phase;
  logic        w_rot_step;
  logic        w_sub_step;
  logic [31:0] w_sb_in;
  logic [31:0] w_sb_out;
  logic [31:0] w_temp;
  logic [31:0] w_word;
  logic        w_last;
  logic        w_advance;

  assign w_nk    = NK_OF(i_mode);
  assign w_legal = (i_mode != MODE_ILL) && (32'(w_nk) <= MAX_NK);

  // Key preloaded reversed so the oldest window slot (w[i-Nk]) yields key
  // word i during the first Nk cycles; no separate key register needed.
  always_comb begin
    for (int unsigned j = 0; j < 8; j++) begin
      w_key_win[j] = '0;
      if (j < 32'(w_nk)) w_key_win[j] = i_key[32*(32'(w_nk)-1-j) +: 32];
    end
  end

  always_comb begin
    case (r_nk)
      4'd8:    w_old = r_win[7];
      4'd6:    w_old = r_win[5];
      default: w_old = r_win[3];
    endcase
    w_key_phase = ({2'b00, r_nk} > r_i);
    w_rot_step  = !w_key_phase && (r_imod == 3'd0);
    w_sub_step  = !w_key_phase && (r_nk == 4'd8) && (r_imod == 3'd4);
    w_sb_in     = w_rot_step ? {r_win[0][23:0], r_win[0][31:24]} : r_win[0];
    if (w_rot_step)      w_temp = w_sb_out ^ {r_rcon, 24'h0};
    else if (w_sub_step) w_temp = w_sb_out;
    else                 w_temp = r_win[0];
    w_word    = w_key_phase ? w_old : (w_old ^ w_temp);
    w_last    = (r_i == {r_nr, 2'b11});
    w_advance = (r_state == S_GEN) && ((r_i[1:0] != 2'b11) || !o_vld || i_rdy);
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .i_a (w_sb_in[8*b +: 8]),
      .o_s (w_sb_out[8*b +: 8])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_nk     <= '0;
      r_nr     <= '0;
      r_i      <= '0;
      r_imod   <= '0;
      r_rcon   <= 8'h01;
      for (int unsigned j = 0; j < 8; j++) r_win[j] <= '0;
      for (int unsigned j = 0; j < 3; j++) r_buf[j] <= '0;
      o_rk     <= '0;
      o_rk_idx <= '0;
      o_vld    <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_vld) begin
            if (w_legal) begin
              r_nk    <= w_nk;
              r_nr    <= NR_OF(i_mode);
              r_i     <= '0;
              r_imod  <= '0;
              r_rcon  <= 8'h01;
              for (int unsigned j = 0; j < 8; j++) r_win[j] <= w_key_win[j];
              o_busy  <= 1'b1;
              r_state <= S_GEN;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        S_GEN: begin
          if (o_vld && i_rdy) o_vld <= 1'b0;
          if (w_advance) begin
            for (int unsigned j = 1; j < 8; j++) r_win[j] <= r_win[j-1];
            r_win[0] <= w_word;
            r_i      <= r_i + 6'd1;
            r_imod   <= ({1'b0, r_imod} == (r_nk - 4'd1)) ? 3'd0 : (r_imod + 3'd1);
            if (w_rot_step) r_rcon <= xtime(r_rcon);
            case (r_i[1:0])
              2'd0: r_buf[0] <= w_word;
              2'd1: r_buf[1] <= w_word;
              2'd2: r_buf[2] <= w_word;
              default: begin
                o_rk     <= {r_buf[0], r_buf[1], r_buf[2], w_word};
                o_rk_idx <= r_i[5:2];
                o_vld    <= 1'b1;
              end
            endcase
            if (w_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (o_vld && i_rdy) begin
            o_vld   <= 1'b0;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_sched_iter.sv
// Bench for aes_key_sched_iter: round keys compared against a textbook
// key-expansion model with an S-box built by the 3/inverse-3 generator walk.
module tb_aes_key_sched_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, vld, vld4, rdy;
  logic [1:0]   mode;
  logic [0:255] key;
  logic [0:127] rk, rk4;
  logic [3:0]   idx, idx4;
  logic         ovld, busy, done, err;
  logic         ovld4, busy4, done4, err4;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]   sbox [256];
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [0:127] exp_rk [15];

  aes_key_sched_iter u_dut (
    .i_clk(clk), .i_rst(rst), .i_vld(vld), .i_mode(mode), .i_key(key),
    .i_rdy(rdy), .o_rk(rk), .o_rk_idx(idx), .o_vld(ovld), .o_busy(busy),
    .o_done(done), .o_err(err)
  );

  aes_key_sched_iter #(.MAX_NK(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_vld(vld4), .i_mode(mode), .i_key(key),
    .i_rdy(rdy), .o_rk(rk4), .o_rk_idx(idx4), .o_vld(ovld4), .o_busy(busy4),
    .o_done(done4), .o_err(err4)
  );

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // p walks the field multiplying by 3, q tracks its inverse (dividing by 3).
  task automatic init_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end
    sbox[0] = 8'h63;
  endtask

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic ref_expand(input int m, input logic [0:255] k);
    int nk, nr;
    logic [31:0] w [60];
    logic [31:0] t;
    nk = 4 + 2*m;
    nr = nk + 6;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) w[i] = k[32*i +: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = {t[23:0], t[31:24]};
          t = subword(t) ^ {rcon_tab[i/nk - 1], 24'h0};
        end else if (nk == 8 && i % nk == 4) begin
          t = subword(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic run_key(input string name, input int m, input logic [0:255] k,
                         input int pct, input bit use_kat, input logic [0:127] kat,
                         input int abort_r, input bit dup);
    int nr, r, e;
    bit rd, stall;
    logic [0:127] p_rk;
    logic [3:0]   p_idx;
    nr = 10 + 2*m; r = 0; e = 0; stall = 0; p_rk = '0; p_idx = '0;
    ref_expand(m, k);
    @(negedge clk); vld = 1'b1; mode = 2'(m); key = k; rdy = 1'b0;
    @(negedge clk); vld = 1'b0;
    n_chk++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    else n_pass++;
    while (r <= nr && e < 400) begin
      if (stall) begin
        n_chk++;
        if ({ovld, idx, rk} !== {1'b1, p_idx, p_rk})
          $display("FAIL %s stall_stable e=%0d: got vld=%b idx=%0d rk=%h want vld=1 idx=%0d rk=%h",
                   name, e, ovld, idx, rk, p_idx, p_rk);
        else n_pass++;
      end
      if (dup && e == 10) begin vld = 1'b1; mode = 2'd2; key = ~k; end
      else vld = 1'b0;
      if (dup && e == 11) begin
        n_chk++;
        if ({busy, err} !== 2'b10) $display("FAIL %s dup_start_ignored: got busy=%b err=%b want busy=1 err=0", name, busy, err);
        else n_pass++;
      end
      rd = ($urandom_range(99) < pct);
      rdy = rd;
      if (ovld && rd) begin
        n_chk++;
        if (idx !== 4'(r)) $display("FAIL %s rk_idx: got %0d want %0d", name, idx, r);
        else n_pass++;
        n_chk++;
        if (rk !== exp_rk[r]) $display("FAIL %s rk[%0d]: got %h want %h", name, r, rk, exp_rk[r]);
        else n_pass++;
        if (pct >= 100) begin
          n_chk++;
          if (e != 4 + 4*r) $display("FAIL %s rk[%0d]_latency: got T0+%0d want T0+%0d", name, r, e, 4 + 4*r);
          else n_pass++;
        end
        if (use_kat && r == nr) begin
          n_chk++;
          if (rk !== kat) $display("FAIL %s kat_last_rk: got %h want %h", name, rk, kat);
          else n_pass++;
        end
        r++;
        if (r == abort_r + 1) begin
          @(negedge clk); rst = 1'b1; #1;
          n_chk++;
          if ({rk, idx, ovld, busy, done, err} !== '0)
            $display("FAIL %s reset_mid: got rk=%h idx=%0d vld=%b busy=%b done=%b err=%b want all 0",
                     name, rk, idx, ovld, busy, done, err);
          else n_pass++;
          @(negedge clk); rst = 1'b0; rdy = 1'b1;
          repeat (3) begin
            @(negedge clk);
            n_chk++;
            if ({done, busy, ovld} !== 3'b000) $display("FAIL %s after_abort: got done=%b busy=%b vld=%b want 0", name, done, busy, ovld);
            else n_pass++;
          end
          return;
        end
      end
      stall = ovld && !rd;
      p_rk = rk;
      p_idx = idx;
      @(negedge clk);
      e++;
    end
    n_chk++;
    if (r <= nr) begin
      $display("FAIL %s timeout: got %0d round keys want %0d", name, r, nr + 1);
    end else begin
      if ({done, busy, ovld} !== 3'b100) $display("FAIL %s done_pulse: got done=%b busy=%b vld=%b want 1 0 0", name, done, busy, ovld);
      else n_pass++;
      rdy = 1'b0;
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0) $display("FAIL %s done_one_cycle: got %b want 0", name, done);
      else n_pass++;
    end
  endtask

  localparam logic [0:255] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [0:255] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({rk, idx, ovld, busy, done, err} !== '0)
      $display("FAIL reset_state: got rk=%h idx=%0d vld=%b busy=%b done=%b err=%b want all 0", rk, idx, ovld, busy, done, err);
    else n_pass++;
    n_chk++;
    if ({ovld4, busy4, err4} !== 3'b000) $display("FAIL reset_state_dut4: got vld=%b busy=%b err=%b want 0", ovld4, busy4, err4);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_kat();
    run_key("kat128", 0, K128, 100, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, -1, 1'b0);
    run_key("kat192", 1, K192, 100, 1'b1, 128'he98ba06f448c773c8ecc720401002202, -1, 1'b0);
    run_key("kat256", 2, K256, 100, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    run_key("bp128", 0, K128, 30, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, -1, 1'b0);
  endtask

  task automatic test_illegal();
    @(negedge clk); vld = 1'b1; mode = 2'd3;
    @(negedge clk); vld = 1'b0;
    n_chk++;
    if ({busy, err} !== 2'b01) $display("FAIL illegal_mode_err: got busy=%b err=%b want 0 1", busy, err);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({busy, err, ovld} !== 3'b000) $display("FAIL illegal_mode_after: got busy=%b err=%b vld=%b want 0", busy, err, ovld);
    else n_pass++;
    vld4 = 1'b1; mode = 2'd2;
    @(negedge clk); vld4 = 1'b0;
    n_chk++;
    if ({busy4, err4} !== 2'b01) $display("FAIL maxnk_reject_err: got busy=%b err=%b want 0 1", busy4, err4);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({busy4, err4, ovld4} !== 3'b000) $display("FAIL maxnk_reject_after: got busy=%b err=%b vld=%b want 0", busy4, err4, ovld4);
    else n_pass++;
  endtask

  task automatic test_dup_start();
    run_key("dup128", 0, K128, 60, 1'b0, '0, -1, 1'b1);
  endtask

  task automatic test_reset_mid();
    run_key("abort128", 0, K128, 100, 1'b0, '0, 3, 1'b0);
    run_key("restart128", 0, K128, 100, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, -1, 1'b0);
  endtask

  task automatic test_random();
    logic [0:255] k;
    int m;
    for (int t = 0; t < 4; t++) begin
      for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom();
      m = $urandom_range(2);
      run_key("rand", m, k, 50, 1'b0, '0, -1, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b0; vld = 1'b0; vld4 = 1'b0; rdy = 1'b0; mode = '0; key = '0;
    init_sbox();
    test_reset();
    test_kat();
    test_backpressure();
    test_illegal();
    test_dup_start();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
